alu_ctrl_seq: RTL and testbench

- Registered, handshaked successor of the combinational ALU control decoder.
- Decodes alu_op/funct3/funct7 into the ALU control code.
- Adds RV32M mul/div decode, flags illegal encodings, and sequences fixed-latency multi-cycle operations. It issues a start pulse to the multi-cycle unit and stalls the execute stage until the result slot is valid.
- Sits between the decode/issue stage and the execute datapath.

---
 rtl/alu_ctrl_pkg.sv | 22 ++
 rtl/alu_ctrl_seq_if.sv | 28 ++
 rtl/alu_ctrl_decode.sv | 88 ++++++++
 rtl/alu_ctrl_seq.sv | 150 +++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, op-class / funct7 encodings and sequencer state type.
// Used by alu_ctrl_seq and alu_ctrl_decode (RV32M gated by ALU_CTRL_SEQ_M_EXT_EN).
package alu_ctrl_pkg;
  localparam int unsigned CODE_W = 5;
  typedef logic [CODE_W-1:0] code_t;

  localparam code_t ALU_ADD    = 5'd0,  ALU_SLL   = 5'd1,  ALU_SRA  = 5'd2,  ALU_SUB  = 5'd3,
                    ALU_XOR    = 5'd4,  ALU_JAL   = 5'd5,  ALU_LUI  = 5'd6,  ALU_BGE  = 5'd7,
                    ALU_BNE    = 5'd8,  ALU_OR    = 5'd9,  ALU_AND  = 5'd10, ALU_SRL  = 5'd11,
                    ALU_SLT    = 5'd12, ALU_SLTU  = 5'd13, ALU_BEQ  = 5'd14, ALU_BLT  = 5'd15,
                    ALU_BLTU   = 5'd16, ALU_BGEU  = 5'd17, ALU_MUL  = 5'd18, ALU_MULH = 5'd19,
                    ALU_MULHSU = 5'd20, ALU_MULHU = 5'd21, ALU_DIV  = 5'd22, ALU_DIVU = 5'd23,
                    ALU_REM    = 5'd24, ALU_REMU  = 5'd25;

  localparam logic [2:0] OP_RTYPE  = 3'b000, OP_IARITH = 3'b101, OP_LDST = 3'b110,
                         OP_BRANCH = 3'b010, OP_JAL    = 3'b011, OP_LUI  = 3'b001,
                         OP_AUIPC  = 3'b100;

  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_WAIT} state_t;
endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Decode-to-execute handshake bundle of alu_ctrl_seq; slave = sequencer, master = issue side.
interface alu_ctrl_seq_if #(
  parameter int unsigned ALU_CTRL_W = 5
) ();
  logic                  flush_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [2:0]            alu_op_i;
  logic [2:0]            funct_3_i;
  logic [6:0]            funct_7_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [ALU_CTRL_W-1:0] alu_ctrl_o;
  logic                  illegal_o;
  logic                  multicycle_o;
  logic                  mc_start_o;
  logic                  busy_o;

  modport slave (
    input  flush_i, in_valid_i, alu_op_i, funct_3_i, funct_7_i, out_ready_i,
    output in_ready_o, out_valid_o, alu_ctrl_o, illegal_o, multicycle_o, mc_start_o, busy_o
  );

  modport master (
    output flush_i, in_valid_i, alu_op_i, funct_3_i, funct_7_i, out_ready_i,
    input  in_ready_o, out_valid_o, alu_ctrl_o, illegal_o, multicycle_o, mc_start_o, busy_o
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational alu_op/funct3/funct7 -> ALU control decode.
// RV32M rows exist only with ALU_CTRL_SEQ_M_EXT_EN; otherwise funct7 0000001 is illegal.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 5
) (
  input  logic [2:0]            alu_op_i,
  input  logic [2:0]            funct_3_i,
  input  logic [6:0]            funct_7_i,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  output logic                  illegal_o,
  output logic                  is_mul_o,
  output logic                  is_div_o
);
  code_t code;

  always_comb begin
    code      = ALU_ADD;
    illegal_o = 1'b0;
    is_mul_o  = 1'b0;
    is_div_o  = 1'b0;
    case (alu_op_i)
      OP_RTYPE: begin
        if (funct_7_i == F7_BASE) begin
          case (funct_3_i)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
          endcase
        end else if (funct_7_i == F7_ALT) begin
          case (funct_3_i)
            3'b000:  code = ALU_SUB;
            3'b101:  code = ALU_SRA;
            default: illegal_o = 1'b1;
          endcase
`ifdef ALU_CTRL_SEQ_M_EXT_EN
        end else if (funct_7_i == F7_MEXT) begin
          // mul..remu are consecutive codes in funct3 order
          code     = ALU_MUL + code_t'(funct_3_i);
          is_mul_o = !funct_3_i[2];
          is_div_o = funct_3_i[2];
`endif
        end else begin
          illegal_o = 1'b1;
        end
      end
      OP_IARITH: begin
        case (funct_3_i)
          3'b000:  code = ALU_ADD;
          3'b010:  code = ALU_SLT;
          3'b011:  code = ALU_SLTU;
          3'b100:  code = ALU_XOR;
          3'b110:  code = ALU_OR;
          3'b111:  code = ALU_AND;
          3'b001:  if (funct_7_i == F7_BASE) code = ALU_SLL; else illegal_o = 1'b1;
          default: begin
            if (funct_7_i == F7_BASE)     code = ALU_SRL;
            else if (funct_7_i == F7_ALT) code = ALU_SRA;
            else                          illegal_o = 1'b1;
          end
        endcase
      end
      OP_LDST, OP_AUIPC: code = ALU_ADD;
      OP_BRANCH: begin
        case (funct_3_i)
          3'b000:  code = ALU_BEQ;
          3'b001:  code = ALU_BNE;
          3'b100:  code = ALU_BLT;
          3'b101:  code = ALU_BGE;
          3'b110:  code = ALU_BLTU;
          3'b111:  code = ALU_BGEU;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_JAL:  code = ALU_JAL;
      OP_LUI:  code = ALU_LUI;
      default: illegal_o = 1'b1;
    endcase
  end

  assign alu_ctrl_o = illegal_o ? '0 : ALU_CTRL_W'(code);
endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control with fixed-latency mul/div sequencing.
// Multi-cycle support (counter, mc_start/busy/multicycle) only with ALU_CTRL_SEQ_M_EXT_EN.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ALU_CTRL_W = 5,
  parameter int unsigned MUL_LAT    = 3,
  parameter int unsigned DIV_LAT    = XLEN + 1
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  alu_ctrl_seq_if.slave  bus
);
  if (MUL_LAT < 2 || DIV_LAT < 2) begin : g_lat_check
    $error("alu_ctrl_seq: MUL_LAT and DIV_LAT must both be >= 2");
  end

  state_t                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic                  illegal_q, illegal_d;
  logic [ALU_CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [ALU_CTRL_W-1:0] dec_ctrl;
  logic                  dec_ill, dec_mul, dec_div;
  logic                  in_ready, accept, mc_go, cnt_done;

  alu_ctrl_decode #(.ALU_CTRL_W(ALU_CTRL_W)) u_decode (
    .alu_op_i   (bus.alu_op_i),
    .funct_3_i  (bus.funct_3_i),
    .funct_7_i  (bus.funct_7_i),
    .alu_ctrl_o (dec_ctrl),
    .illegal_o  (dec_ill),
    .is_mul_o   (dec_mul),
    .is_div_o   (dec_div)
  );

  assign in_ready = !bus.flush_i &&
                    (state_q == S_IDLE || (state_q == S_RESP && bus.out_ready_i));
  assign accept   = bus.in_valid_i && in_ready;
  assign mc_go    = dec_mul | dec_div;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_ctrl_d  = alu_ctrl_q;
    illegal_d   = illegal_q;
    if (bus.flush_i) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else if (accept) begin
      alu_ctrl_d  = dec_ctrl;
      illegal_d   = dec_ill;
      state_d     = mc_go ? S_WAIT : S_RESP;
      out_valid_d = !mc_go;
    end else begin
      case (state_q)
        S_RESP: if (bus.out_ready_i) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
        S_WAIT: if (cnt_done) begin
          state_d     = S_RESP;
          out_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      alu_ctrl_q  <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_ctrl_q  <= alu_ctrl_d;
      illegal_q   <= illegal_d;
    end
  end

`ifdef ALU_CTRL_SEQ_M_EXT_EN
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mc_start_q, mc_start_d;
  logic             busy_q, busy_d;
  logic             multicycle_q, multicycle_d;

  // Counter loads LAT-1 so the result lands exactly LAT cycles after acceptance.
  always_comb begin
    cnt_d        = cnt_q;
    mc_start_d   = 1'b0;
    busy_d       = busy_q;
    multicycle_d = multicycle_q;
    if (bus.flush_i) begin
      cnt_d        = '0;
      busy_d       = 1'b0;
      multicycle_d = 1'b0;
    end else if (accept) begin
      multicycle_d = 1'b0;
      if (mc_go) begin
        cnt_d      = dec_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
        mc_start_d = 1'b1;
        busy_d     = 1'b1;
      end
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_done) begin
        busy_d       = 1'b0;
        multicycle_d = 1'b1;
      end
    end else if (state_q == S_RESP && bus.out_ready_i) begin
      multicycle_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q        <= '0;
      mc_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      multicycle_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      mc_start_q   <= mc_start_d;
      busy_q       <= busy_d;
      multicycle_q <= multicycle_d;
    end
  end

  assign cnt_done         = (cnt_q == CNT_W'(1));
  assign bus.mc_start_o   = mc_start_q;
  assign bus.busy_o       = busy_q;
  assign bus.multicycle_o = multicycle_q;
`else
  assign cnt_done         = 1'b0;
  assign bus.mc_start_o   = 1'b0;
  assign bus.busy_o       = 1'b0;
  assign bus.multicycle_o = 1'b0;
`endif

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.alu_ctrl_o  = alu_ctrl_q;
  assign bus.illegal_o   = illegal_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq; RV32M cases run when ALU_CTRL_SEQ_M_EXT_EN is defined.
module tb_alu_ctrl_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_ctrl_seq_if #(.ALU_CTRL_W(5)) bus ();

  alu_ctrl_seq #(.XLEN(32), .ALU_CTRL_W(5), .MUL_LAT(3), .DIV_LAT(33)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] ctrl;
    logic       ill;
    logic       mc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned mc_seen  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (bus.mc_start_o || bus.busy_o) mc_seen++;
    if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
      if (sb.size() == 0) check("unexpected_out", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("alu_ctrl",   bus.alu_ctrl_o,   mon_e.ctrl);
        check("illegal",    bus.illegal_o,    mon_e.ill);
        check("multicycle", bus.multicycle_o, mon_e.mc);
      end
    end
  end

  // Present one op; returns at (accepting edge)+1 with in_valid dropped.
  task automatic drive(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] ctrl, input logic ill, input logic mc,
                       input bit keep, output int unsigned waited);
    int unsigned n = 0;
    bus.in_valid_i = 1'b1;
    bus.alu_op_i   = op;
    bus.funct_3_i  = f3;
    bus.funct_7_i  = f7;
    @(negedge clk);
    while (!bus.in_ready_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("accept_timeout", 0, 1);
    if (keep) sb.push_back('{ctrl: ctrl, ill: ill, mc: mc});
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    waited = n;
  endtask

  task automatic sc(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                    input logic [4:0] ctrl, input logic ill);
    int unsigned w;
    drive(op, f3, f7, ctrl, ill, 1'b0, 1'b1, w);
  endtask

  task automatic quiet(input string tag, input int unsigned cycles);
    int unsigned seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.out_valid_o) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    int unsigned w;
    int unsigned bad;
    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.alu_op_i    = '0;
    bus.funct_3_i   = '0;
    bus.funct_7_i   = '0;
    bus.out_ready_i = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_alu_ctrl",  bus.alu_ctrl_o,  0);
    check("rst_busy",      bus.busy_o,      0);
    check("rst_mc_start",  bus.mc_start_o,  0);
    check("rst_in_ready",  bus.in_ready_o,  1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back sub then bgeu, no bubble
    drive(3'b000, 3'b000, 7'b0100000, 5'd3, 1'b0, 1'b0, 1'b1, w);
    check("b2b_valid0", bus.out_valid_o, 1);
    check("b2b_ctrl0",  bus.alu_ctrl_o,  3);
    drive(3'b010, 3'b111, 7'b0000000, 5'd17, 1'b0, 1'b0, 1'b1, w);
    check("b2b_nobubble", w, 0);
    check("b2b_valid1",   bus.out_valid_o, 1);
    check("b2b_ctrl1",    bus.alu_ctrl_o,  17);

    // base decode sweep
    sc(3'b000, 3'b000, 7'h00, 5'd0,  1'b0);
    sc(3'b000, 3'b001, 7'h00, 5'd1,  1'b0);
    sc(3'b000, 3'b010, 7'h00, 5'd12, 1'b0);
    sc(3'b000, 3'b011, 7'h00, 5'd13, 1'b0);
    sc(3'b000, 3'b100, 7'h00, 5'd4,  1'b0);
    sc(3'b000, 3'b101, 7'h00, 5'd11, 1'b0);
    sc(3'b000, 3'b110, 7'h00, 5'd9,  1'b0);
    sc(3'b000, 3'b111, 7'h00, 5'd10, 1'b0);
    sc(3'b000, 3'b101, 7'h20, 5'd2,  1'b0);
    sc(3'b000, 3'b100, 7'h20, 5'd0,  1'b1);
    sc(3'b000, 3'b000, 7'h7f, 5'd0,  1'b1);
    sc(3'b101, 3'b000, 7'h55, 5'd0,  1'b0);
    sc(3'b101, 3'b010, 7'h00, 5'd12, 1'b0);
    sc(3'b101, 3'b011, 7'h00, 5'd13, 1'b0);
    sc(3'b101, 3'b100, 7'h00, 5'd4,  1'b0);
    sc(3'b101, 3'b110, 7'h00, 5'd9,  1'b0);
    sc(3'b101, 3'b111, 7'h00, 5'd10, 1'b0);
    sc(3'b101, 3'b001, 7'h00, 5'd1,  1'b0);
    sc(3'b101, 3'b101, 7'h00, 5'd11, 1'b0);
    sc(3'b101, 3'b101, 7'h20, 5'd2,  1'b0);
    sc(3'b101, 3'b001, 7'h20, 5'd0,  1'b1);
    sc(3'b110, 3'b010, 7'h11, 5'd0,  1'b0);
    sc(3'b100, 3'b000, 7'h33, 5'd0,  1'b0);
    sc(3'b001, 3'b000, 7'h00, 5'd6,  1'b0);
    sc(3'b011, 3'b000, 7'h00, 5'd5,  1'b0);
    sc(3'b010, 3'b000, 7'h00, 5'd14, 1'b0);
    sc(3'b010, 3'b001, 7'h00, 5'd8,  1'b0);
    sc(3'b010, 3'b100, 7'h00, 5'd15, 1'b0);
    sc(3'b010, 3'b101, 7'h00, 5'd7,  1'b0);
    sc(3'b010, 3'b110, 7'h00, 5'd16, 1'b0);
    sc(3'b010, 3'b010, 7'h00, 5'd0,  1'b1);
    sc(3'b010, 3'b011, 7'h00, 5'd0,  1'b1);
    sc(3'b111, 3'b000, 7'h00, 5'd0,  1'b1);

    // backpressure: xori held for 5 cycles, lui waiting
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b0;
    drive(3'b101, 3'b100, 7'h00, 5'd4, 1'b0, 1'b0, 1'b1, w);
    bus.in_valid_i = 1'b1;
    bus.alu_op_i   = 3'b001;
    bus.funct_3_i  = 3'b000;
    bus.funct_7_i  = 7'h00;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!bus.out_valid_o || bus.alu_ctrl_o != 5'd4 || bus.in_ready_o) bad++;
    end
    check("bp_hold", bad, 0);
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b1;
    drive(3'b001, 3'b000, 7'h00, 5'd6, 1'b0, 1'b0, 1'b1, w);
    check("bp_release_same_cycle", w, 0);
    @(posedge clk);
    #1;

    // flush coinciding with in_valid drops the input
    bus.flush_i    = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.alu_op_i   = 3'b000;
    bus.funct_3_i  = 3'b000;
    bus.funct_7_i  = 7'h00;
    @(negedge clk);
    check("flush_in_ready", bus.in_ready_o, 0);
    @(posedge clk);
    #1;
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    quiet("flush_drop", 4);

    // reset while a result is held
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b0;
    drive(3'b010, 3'b001, 7'h00, 5'd8, 1'b0, 1'b0, 1'b0, w);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_hold_valid", bus.out_valid_o, 0);
    check("rst_hold_ctrl",  bus.alu_ctrl_o,  0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_ready", bus.in_ready_o, 1);

`ifdef ALU_CTRL_SEQ_M_EXT_EN
    // div latency profile
    drive(3'b000, 3'b100, 7'b0000001, 5'd22, 1'b0, 1'b1, 1'b1, w);
    check("div_start",  bus.mc_start_o,  1);
    check("div_busy",   bus.busy_o,      1);
    check("div_nvalid", bus.out_valid_o, 0);
    check("div_ctrl",   bus.alu_ctrl_o,  22);
    bad = 0;
    for (int k = 2; k <= 32; k++) begin
      @(posedge clk);
      #1;
      if (bus.mc_start_o || !bus.busy_o || bus.out_valid_o || bus.in_ready_o ||
          bus.alu_ctrl_o != 5'd22) bad++;
    end
    check("div_wait", bad, 0);
    @(posedge clk);
    #1;
    check("div_valid",      bus.out_valid_o,  1);
    check("div_multicycle", bus.multicycle_o, 1);
    check("div_busy_drop",  bus.busy_o,       0);

    // all RV32M ops through the scoreboard, mixed with a single-cycle op
    for (int f = 0; f < 8; f++) begin
      logic [2:0] f3;
      logic [4:0] cexp;
      f3   = 3'(f);
      cexp = 5'(18 + f);
      drive(3'b000, f3, 7'b0000001, cexp, 1'b0, 1'b1, 1'b1, w);
    end
    sc(3'b000, 3'b000, 7'h20, 5'd3, 1'b0);

    // flush while mc_start is high (mulhu)
    @(posedge clk);
    #1;
    drive(3'b000, 3'b011, 7'b0000001, 5'd21, 1'b0, 1'b1, 1'b0, w);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    check("flush_mul_start", bus.mc_start_o, 0);
    check("flush_mul_busy",  bus.busy_o,     0);
    check("flush_mul_ready", bus.in_ready_o, 1);
    quiet("flush_mul_quiet", 10);

    // flush at t+10 of a div
    drive(3'b000, 3'b101, 7'b0000001, 5'd23, 1'b0, 1'b1, 1'b0, w);
    repeat (9) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    check("flush_div_busy",  bus.busy_o,     0);
    check("flush_div_ready", bus.in_ready_o, 1);
    quiet("flush_div_quiet", 40);

    // reset mid-WAIT
    drive(3'b000, 3'b110, 7'b0000001, 5'd24, 1'b0, 1'b1, 1'b0, w);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rstw_busy",       bus.busy_o,       0);
    check("rstw_mc_start",   bus.mc_start_o,   0);
    check("rstw_out_valid",  bus.out_valid_o,  0);
    check("rstw_multicycle", bus.multicycle_o, 0);
    check("rstw_ctrl",       bus.alu_ctrl_o,   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rstw_ready", bus.in_ready_o, 1);
    quiet("rstw_no_late_valid", 40);
    check("mc_activity", (mc_seen != 0), 1);
`else
    // without RV32M: mul is a single-cycle illegal
    drive(3'b000, 3'b000, 7'b0000001, 5'd0, 1'b1, 1'b0, 1'b1, w);
    check("mul_ill_valid", bus.out_valid_o, 1);
    check("mul_ill_start", bus.mc_start_o,  0);
    drive(3'b000, 3'b100, 7'b0000001, 5'd0, 1'b1, 1'b0, 1'b1, w);
    check("div_ill_busy", bus.busy_o, 0);
    @(posedge clk);
    #1;
    check("no_mc_activity", mc_seen, 0);
`endif

    bad = 0;
    while (sb.size() != 0 && bad < 200) begin
      bad++;
      @(posedge clk);
    end
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
